// File: rtl/display_pkg.sv
// Shared constants, segment table and scan-rate helpers for the display scan controller.
package display_pkg;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_state_t;

  // Active-low, seg[0]=a .. seg[6]=g; non-BCD nibbles render as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  function automatic int calc_tick_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  function automatic bit tick_div_ok(input int td);
    return td >= 2;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
module seg_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(nibble);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a one-entry pending slot
// that is committed only at frame boundaries so frames never tear.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int SCAN_HZ = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [15:0] in_bcd,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  seg,
  output logic [3:0]  n_digit,
  output logic        frame_done
);

  localparam int TICK_DIV = calc_tick_div(CLK_HZ, SCAN_HZ);
  localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  generate
    if (!tick_div_ok(TICK_DIV)) begin : g_bad_div
      $error("display_scan_ctrl: CLK_HZ/SCAN_HZ must be at least 2");
    end
  endgenerate

  scan_state_t state, state_nxt;
  logic [PW-1:0] pscl;
  logic [1:0]    idx;
  logic [15:0]   shown, pend;
  logic          pend_full;
  logic          tick, boundary, drive;

  logic [NUM_DIGITS-1:0][6:0] dec;
  logic [NUM_DIGITS-1:0]      blank;

  // Decode every digit in parallel; the scan index only selects among them.
  generate
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      seg_decode u_dec (.nibble(shown[4*d +: 4]), .seg(dec[d]));
      if (d == 0) begin : g_lsd
        assign blank[d] = 1'b0;
      end else begin : g_msd
        assign blank[d] = blank_lz && (shown[15:4*d] == '0);
      end
    end
  endgenerate

  assign in_ready = ~pend_full;
  assign tick     = (state == SCAN) && (pscl == PMAX);
  assign boundary = tick && (idx == 2'd3);
  // Outputs go dark on the same edge that leaves SCAN.
  assign drive    = (state == SCAN) && enable;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = SCAN;
      SCAN:    if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pscl       <= '0;
      idx        <= '0;
      shown      <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      seg        <= SEG_OFF;
      n_digit    <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      if (drive) begin
        pscl <= tick ? '0 : pscl + 1'b1;
        if (tick) idx <= idx + 2'd1;
      end else begin
        pscl <= '0;
        idx  <= '0;
      end

      // Capture and commit are mutually exclusive: capture needs an empty slot.
      if (in_valid && !pend_full) begin
        pend      <= in_bcd;
        pend_full <= 1'b1;
      end else if (boundary && pend_full) begin
        shown     <= pend;
        pend_full <= 1'b0;
      end

      frame_done <= boundary;

      if (drive) begin
        n_digit <= ~(4'b0001 << idx);
        seg     <= blank[idx] ? SEG_OFF : dec[idx];
      end else begin
        n_digit <= 4'b1111;
        seg     <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected per-cycle digit drives and status
// probes; a negedge monitor pops and compares them against the scanner.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, blank_lz, in_valid;
  logic [15:0] in_bcd;
  logic        in_ready, frame_done;
  logic [6:0]  seg;
  logic [3:0]  n_digit;

  display_scan_ctrl #(.CLK_HZ(40), .SCAN_HZ(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .blank_lz(blank_lz),
    .in_bcd(in_bcd), .in_valid(in_valid), .in_ready(in_ready),
    .seg(seg), .n_digit(n_digit), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] nd;
    logic [6:0] sg;
    logic       fd;
  } exp_t;

  typedef struct {
    string name;
    logic  rdy;
    bit    idle;
    bit    drain;
  } stat_t;

  exp_t  q[$];
  stat_t sq[$];
  int    checks = 0;
  int    errors = 0;
  int    t = 0;

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h3F;
    endcase
  endfunction

  // One entry per driven cycle: 4 cycles per digit, frame_done on the 16th.
  task automatic push_cycles(input logic [15:0] v, input bit blz, input int n);
    exp_t e;
    int d;
    for (int c = 0; c < n; c++) begin
      d = c / 4;
      e.nd = 4'hF;
      e.nd[d] = 1'b0;
      e.sg = (blz && d > 0 && (v >> (4*d)) == 16'h0) ? 7'h7F : exp_seg(v[4*d +: 4]);
      e.fd = (c == 15);
      q.push_back(e);
    end
  endtask

  task automatic expect_status(input string name, input logic rdy, input bit idle, input bit drain);
    stat_t s;
    s.name = name; s.rdy = rdy; s.idle = idle; s.drain = drain;
    sq.push_back(s);
  endtask

  task automatic go(input int e);
    while (t < e) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    in_valid = 1'b1;
    in_bcd   = v;
  endtask

  exp_t  me;
  stat_t ms;
  always @(negedge clk) begin
    if (sq.size() > 0) begin
      ms = sq.pop_front();
      checks++;
      if (in_ready !== ms.rdy ||
          (ms.idle && (seg !== 7'h7F || n_digit !== 4'hF || frame_done !== 1'b0)) ||
          (ms.drain && q.size() != 0)) begin
        errors++;
        $display("FAIL %s: got rdy=%b seg=%b nd=%b fd=%b left=%0d, want rdy=%b idle=%0d drain=%0d",
                 ms.name, in_ready, seg, n_digit, frame_done, q.size(), ms.rdy, ms.idle, ms.drain);
      end
    end
    if (n_digit !== 4'hF) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_drive: got nd=%b seg=%b, want no drive", n_digit, seg);
      end else begin
        me = q.pop_front();
        checks++;
        if (n_digit !== me.nd || seg !== me.sg || frame_done !== me.fd) begin
          errors++;
          $display("FAIL digit_drive: got nd=%b seg=%b fd=%b, want nd=%b seg=%b fd=%b",
                   n_digit, seg, frame_done, me.nd, me.sg, me.fd);
        end
      end
    end else if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL stray_frame_done: got fd=%b with display dark, want 0", frame_done);
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; blank_lz = 1'b0; in_valid = 1'b0; in_bcd = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_status("reset", 1'b1, 1, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    expect_status("idle_20", 1'b1, 1, 0);

    // Captured while idle: held pending, first frame still shows 0000.
    send(16'h1234);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_status("capture_idle", 1'b0, 1, 0);
    push_cycles(16'h0000, 0, 16);
    push_cycles(16'h1234, 0, 16);
    enable = 1'b1;
    t = 0;

    go(20); send(16'h1111);
    go(21); in_valid = 1'b0;
    expect_status("pending_1111", 1'b0, 0, 0);
    push_cycles(16'h1111, 0, 16);
    push_cycles(16'h2222, 0, 16);
    go(24); send(16'h2222);
    go(32); expect_status("held_off", 1'b0, 0, 0);
    go(33); expect_status("commit_wins", 1'b1, 0, 0);
    go(34); expect_status("capture_2222", 1'b0, 0, 0);
    in_valid = 1'b0;

    go(50); blank_lz = 1'b1; send(16'h0050);
    go(51); in_valid = 1'b0;
    push_cycles(16'h0050, 1, 16);
    go(66); send(16'h0000);
    go(67); in_valid = 1'b0;
    push_cycles(16'h0000, 1, 16);
    go(82); send(16'h00A0);
    go(83); in_valid = 1'b0;
    push_cycles(16'h00A0, 1, 16);
    push_cycles(16'h00A0, 1, 9);

    // Disable while digit 2 is on, then restart from digit 0.
    go(122); enable = 1'b0;
    go(126); enable = 1'b1;
    push_cycles(16'h00A0, 1, 8);
    go(130); send(16'h0999);
    go(131); in_valid = 1'b0;
    expect_status("pending_0999", 1'b0, 0, 0);

    // Reset mid-frame discards the pending 0999.
    go(135); rst = 1'b1;
    go(136); expect_status("reset_mid", 1'b1, 1, 0);
    rst = 1'b0;
    push_cycles(16'h0000, 1, 16);
    push_cycles(16'h0000, 1, 16);
    go(169); enable = 1'b0;
    go(175); expect_status("drain", 1'b1, 1, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan controller for the board's 4-digit multiplexed seven-segment display. It accepts a 16-bit packed-BCD value from any producer through a valid/ready handshake and holds it in a one-entry pending slot. The pending value is committed only at a frame boundary, so a frame never mixes old and new digits. The block time-multiplexes the four digit enables at a parameterised scan rate, with leading-zero blanking and an enable/blank control; it replaces ad-hoc refresh counters in top-level counter designs.

## Interface
- CLK_HZ, 50000000: input clock frequency in Hz.
- SCAN_HZ, 240: digit-step rate in Hz; frame rate is SCAN_HZ/4.
- Derived constant TICK_DIV = CLK_HZ/SCAN_HZ (integer division); must be ≥ 2.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = scan the display; 0 = blank the display and hold the scanner idle.
- blank_lz  input  1  1 = suppress leading zeros.
- in_bcd  input  16  four BCD nibbles; [3:0] drives digit 0 (rightmost), [15:12] drives digit 3.
- in_valid  input  1  producer has a value on in_bcd.
- in_ready  output  1  pending slot is empty.
- seg  output  7  segment drive, active-low, seg[0]=a … seg[6]=g; registered.
- n_digit  output  4  digit enables, active-low, one-cold; registered.
- frame_done  output  1  one-cycle pulse on every frame-boundary tick.

## Operation
- Reset values:
  - shown register = 16'h0000; pending slot empty; in_ready = 1.
  - digit index = 0; prescaler = 0; state IDLE.
  - seg = 7'b1111111; n_digit = 4'b1111; frame_done = 0.
- Handshake:
  - Capture occurs when in_valid && in_ready. in_ready falls the next cycle.
  - in_bcd is don't-care when in_valid = 0.
  - A producer may hold in_valid high indefinitely; no capture happens while in_ready = 0.
- State machine with two states:
  - IDLE: prescaler and index held at 0; seg = 7'b1111111; n_digit = 4'b1111. Go to SCAN when enable = 1.
  - SCAN: prescaler counts 0..TICK_DIV-1 and wraps; tick = (prescaler == TICK_DIV-1). Each tick advances the index 0→1→2→3→0. Go to IDLE when enable = 0, regardless of position in the frame.
- Frame boundary: a tick while index == 3. On that edge:
  - frame_done pulses.
  - If the pending slot is full, shown ← pending, the slot empties, and in_ready = 1 the next cycle.
- Pending commit is independent of state. While IDLE, the pending slot stays full, so in_ready stays 0 until scanning resumes and a boundary occurs.
- Digit output: in SCAN, every cycle registers n_digit = ~(4'b0001 << index) and seg = decode(shown nibble[index]), or 7'b1111111 if that digit is blanked.
- Leading-zero blanking, when blank_lz = 1:
  - Digit k (k = 3..1) is blanked if its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked, so value 0 displays "0".
- Decode:
  - 0–9: standard patterns, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - Nibbles 10–15: dash, 7'b0111111 (segment g only).

## Timing
- Output latency: one cycle from index change to n_digit/seg change.
- After reset, with enable = 1: IDLE→SCAN on the first edge; digit 0 is driven from the second cycle.
- Each digit is driven for exactly TICK_DIV cycles in steady state.
- Commit-to-display: a value committed at a boundary appears on digit 0 the cycle after that boundary. Worst-case capture-to-display is 4·TICK_DIV+1 cycles.
- Simultaneous events:
  - Boundary commit and in_valid on the same cycle: the commit wins. in_ready was 0, so no capture occurs that cycle; capture is possible from the next cycle.
  - enable falls on a boundary tick: the commit still happens; outputs blank the next cycle.
- Reset asserted mid-frame: on the next edge all state returns to reset values and any pending value is discarded.
- Re-enable after IDLE always restarts at digit 0 with a fresh prescaler.

## Structure
- A shared package/header display_pkg holds:
  - SEG_OFF = 7'b1111111 and SEG_DASH = 7'b0111111;
  - the BCD-to-segment table;
  - the TICK_DIV derivation and its ≥ 2 check.
- Combinational sub-module seg_decode: 4-bit nibble in, 7-bit active-low segments out.
- The prescaler, index, FSM, pending slot and blanking logic live in display_scan_ctrl itself.

## Test plan
All scenarios use CLK_HZ = 40, SCAN_HZ = 10, so TICK_DIV = 4.
- Reset/idle: rst high then low, enable = 0 for 20 cycles → seg = 7'b1111111, n_digit = 4'b1111, in_ready = 1, frame_done never pulses.
- Basic scan: enable = 1, send 16'h1234 and wait one full frame → digit 0 shows "4", then "3", "2", "1" each for 4 cycles; n_digit sequence is 1110, 1101, 1011, 0111; frame_done pulses every 16 cycles.
- Handshake/no tearing: send 16'h1111, then present 16'h2222 mid-frame → in_ready = 0 until the next boundary; all four digits of the current frame show 1; 16'h2222 appears starting at the next frame's digit 0.
- Blanking: blank_lz = 1 with value 16'h0050 → digits 3 and 2 are off, digit 1 = "5", digit 0 = "0". Value 16'h0000 → only digit 0 lit, showing "0". Value 16'h00A0 → digit 1 shows a dash.
- Disable mid-frame: drop enable at index 2 → outputs blank the next cycle. Re-enable → digit 0 is driven again one cycle after re-entering SCAN, for a full 4 cycles.
- Reset mid-operation: assert rst while pending is full during SCAN → next cycle in_ready = 1, n_digit = 4'b1111, shown = 0; the discarded pending value is never displayed.
